adder32_error_monitor: RTL

Sequential checker sitting at the output end of a 32-bit adder under test (exact or approximate). It accepts operand pairs and the adder's 33-bit result over a valid/ready handshake and recomputes the exact sum internally. Over a programmed run of NUM_SAMPLES accepted samples it accumulates the error count, the sum of error distances and the maximum error distance. These statistics are the hardware counterpart of the per-design simulation benches used to qualify approximate adders.

---
 rtl/adder_mon_pkg.sv | 31 +++
 rtl/abs_diff33.sv | 16 +
 rtl/adder32_error_monitor.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/adder_mon_pkg.sv
// Shared types and constants for the 32-bit adder error monitor and its helpers.
package adder_mon_pkg;

    localparam int unsigned OP_W      = 32;
    localparam int unsigned RES_W     = 33;
    localparam int unsigned CNT_W     = 32;
    localparam int unsigned DRAIN_CYC = 2;
    localparam int unsigned DRN_W     = $clog2(DRAIN_CYC + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mon_state_e;

    typedef struct packed {
        logic [OP_W-1:0]  add1;
        logic [OP_W-1:0]  add2;
        logic [RES_W-1:0] result;
    } mon_sample_t;

    // Golden reference: plain behavioural addition, independent of any adder under test.
    function automatic logic [RES_W-1:0] exact_sum(
        input logic [OP_W-1:0] a,
        input logic [OP_W-1:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/abs_diff33.sv
// Combinational 33-bit unsigned distance |a - b| with an inequality flag.
module abs_diff33
    import adder_mon_pkg::*;
(
    input  logic [RES_W-1:0] a_i,
    input  logic [RES_W-1:0] b_i,
    output logic [RES_W-1:0] diff_c,
    output logic             neq_c
);

    always_comb begin
        diff_c = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
        neq_c  = (a_i != b_i);
    end

endmodule

// File: rtl/adder32_error_monitor.sv
// Error-statistics monitor for a 32-bit (possibly approximate) adder: counts errors,
// tracks the maximum error distance and a saturating sum of distances over one run.
module adder32_error_monitor
    import adder_mon_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES = 16,
    parameter int unsigned ACC_W       = 48
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              clear_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [OP_W-1:0]   add1_i,
    input  logic [OP_W-1:0]   add2_i,
    input  logic [RES_W-1:0]  result_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  sample_cnt_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [RES_W-1:0]  max_ed_o,
    output logic [ACC_W-1:0]  sum_ed_o
);

    localparam int unsigned      SUM_W      = ACC_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(NUM_SAMPLES - 1);
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(DRAIN_CYC - 1);
    localparam logic [ACC_W-1:0] SUM_MAX    = '1;

    if (ACC_W < RES_W) begin : g_bad_acc_w
        $error("ACC_W must be at least 33");
    end
    if (NUM_SAMPLES == 0) begin : g_bad_num_samples
        $error("NUM_SAMPLES must be at least 1");
    end

    mon_state_e       state_q, state_d;
    logic [DRN_W-1:0] drain_cnt_q, drain_cnt_d;

    logic             s1_vld_q, s1_vld_d;
    mon_sample_t      s1_q, s1_d;
    logic             s2_vld_q, s2_vld_d;
    logic [RES_W-1:0] ed_q, ed_d;
    logic             neq_q, neq_d;

    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [RES_W-1:0] max_ed_q, max_ed_d;
    logic [ACC_W-1:0] sum_ed_q, sum_ed_d;

    logic             xfer_c;
    logic             zero_stats_c;
    logic [RES_W-1:0] exact_c;
    logic [RES_W-1:0] diff_c;
    logic             neq_c;
    logic [SUM_W-1:0] sum_ext_c;

    assign xfer_c    = valid_i && (state_q == RUN);
    assign exact_c   = exact_sum(s1_q.add1, s1_q.add2);
    assign sum_ext_c = {1'b0, sum_ed_q} + SUM_W'(ed_q);

    // S2 distance against the exact sum of the registered S1 operands.
    abs_diff33 u_abs_diff (
        .a_i    (exact_c),
        .b_i    (s1_q.result),
        .diff_c (diff_c),
        .neq_c  (neq_c)
    );

    // Next-state, pipeline advance and statistics update.
    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        s1_vld_d     = xfer_c;
        s1_d         = s1_q;
        s2_vld_d     = s1_vld_q;
        ed_d         = ed_q;
        neq_d        = neq_q;
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        max_ed_d     = max_ed_q;
        sum_ed_d     = sum_ed_q;
        zero_stats_c = 1'b0;

        if (xfer_c) begin
            s1_d         = '{add1: add1_i, add2: add2_i, result: result_i};
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
        end

        if (s1_vld_q) begin
            ed_d  = diff_c;
            neq_d = neq_c;
        end

        if (s2_vld_q) begin
            err_cnt_d = err_cnt_q + CNT_W'(neq_q);
            if (ed_q > max_ed_q) begin
                max_ed_d = ed_q;
            end
            sum_ed_d = sum_ext_c[ACC_W] ? SUM_MAX : sum_ext_c[ACC_W-1:0];
        end

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d      = RUN;
                    zero_stats_c = 1'b1;
                end
            end
            RUN: begin
                if (xfer_c && (sample_cnt_q == LAST_IDX)) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear wins over start in every state.
        if (clear_i) begin
            state_d      = IDLE;
            zero_stats_c = 1'b1;
        end

        if (zero_stats_c) begin
            drain_cnt_d  = '0;
            s1_vld_d     = 1'b0;
            s2_vld_d     = 1'b0;
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            max_ed_d     = '0;
            sum_ed_d     = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            drain_cnt_q  <= '0;
            s1_vld_q     <= 1'b0;
            s1_q         <= '0;
            s2_vld_q     <= 1'b0;
            ed_q         <= '0;
            neq_q        <= 1'b0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            max_ed_q     <= '0;
            sum_ed_q     <= '0;
        end else begin
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            s1_vld_q     <= s1_vld_d;
            s1_q         <= s1_d;
            s2_vld_q     <= s2_vld_d;
            ed_q         <= ed_d;
            neq_q        <= neq_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            max_ed_q     <= max_ed_d;
            sum_ed_q     <= sum_ed_d;
        end
    end

    assign ready_o      = (state_q == RUN);
    assign busy_o       = (state_q == RUN) || (state_q == DRAIN);
    assign done_o       = (state_q == DONE);
    assign sample_cnt_o = sample_cnt_q;
    assign err_cnt_o    = err_cnt_q;
    assign max_ed_o     = max_ed_q;
    assign sum_ed_o     = sum_ed_q;

endmodule
